// File: rtl/snow64_icache_line_fill_responder_if.sv
// Line-fill bus between the icache, the fill responder and memory.
// slave is the responder's view; master is the icache/memory side.
interface snow64_icache_line_fill_responder_if #(
   parameter int WIDTH__LINE_DATA = 256,
   parameter int WIDTH__MEM_DATA  = 64,
   parameter int WIDTH__CPU_ADDR  = 64
);
   logic                        in_icache_req;
   logic [WIDTH__CPU_ADDR-1:0]  in_icache_addr;
   logic                        out_icache_valid;
   logic [WIDTH__LINE_DATA-1:0] out_icache_data;
   logic                        out_mem_req;
   logic [WIDTH__CPU_ADDR-1:0]  out_mem_addr;
   logic                        in_mem_valid;
   logic [WIDTH__MEM_DATA-1:0]  in_mem_data;
   logic                        out_busy;

   modport slave (
      input  in_icache_req, in_icache_addr,
      input  in_mem_valid, in_mem_data,
      output out_icache_valid, out_icache_data,
      output out_mem_req, out_mem_addr, out_busy
   );

   modport master (
      output in_icache_req, in_icache_addr,
      output in_mem_valid, in_mem_data,
      input  out_icache_valid, out_icache_data,
      input  out_mem_req, out_mem_addr, out_busy
   );
endinterface

// File: rtl/snow64_icache_line_fill_responder.sv
// Fetches an icache line as a burst of memory beats and returns it
// to the icache with a one-cycle valid pulse.
module snow64_icache_line_fill_responder #(
   parameter int WIDTH__LINE_DATA = 256,
   parameter int WIDTH__MEM_DATA  = 64,
   parameter int WIDTH__CPU_ADDR  = 64
) (
   input logic clk,
   input logic rst_n,
   snow64_icache_line_fill_responder_if.slave bus
);
   localparam int NUM_BEATS  = WIDTH__LINE_DATA / WIDTH__MEM_DATA;
   localparam int BEAT_BYTES = WIDTH__MEM_DATA / 8;
   localparam int LINE_BYTES = WIDTH__LINE_DATA / 8;
   localparam int LINE_OFF_W = $clog2(LINE_BYTES);
   localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      RESP
   } state_t;

   state_t                      state;
   state_t                      nextState;
   logic [BEAT_W-1:0]           beat;
   logic [BEAT_W-1:0]           nextBeat;
   logic [WIDTH__CPU_ADDR-1:0]  base;
   logic [WIDTH__CPU_ADDR-1:0]  nextBase;
   logic [WIDTH__CPU_ADDR-1:0]  beatOffset;
   logic [WIDTH__LINE_DATA-1:0] lineBuf;
   logic                        bufWe;
   logic                        memReq;
   logic [WIDTH__CPU_ADDR-1:0]  memAddr;

   always_comb begin
      nextState = state;
      nextBeat  = beat;
      nextBase  = base;
      bufWe     = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.in_icache_req) begin
               nextState = FETCH;
               nextBeat  = '0;
               nextBase  = {bus.in_icache_addr[WIDTH__CPU_ADDR-1:LINE_OFF_W],
                            LINE_OFF_W'(0)};
            end
         end
         FETCH: begin
            if (bus.in_mem_valid) begin
               bufWe = 1'b1;
               if (beat == LAST_BEAT)
                  nextState = RESP;
               else
                  nextBeat = beat + BEAT_W'(1);
            end
         end
         RESP: begin
            nextState = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Beat address is registered from next-state values so it lines up
   // with the beat the FSM will be waiting on next cycle.
   assign beatOffset = WIDTH__CPU_ADDR'(nextBeat)
                     * WIDTH__CPU_ADDR'(BEAT_BYTES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         beat    <= '0;
         base    <= '0;
         lineBuf <= '0;
         memReq  <= 1'b0;
         memAddr <= '0;
      end else begin
         state <= nextState;
         beat  <= nextBeat;
         base  <= nextBase;
         if (bufWe)
            lineBuf[int'(beat)*WIDTH__MEM_DATA +: WIDTH__MEM_DATA]
               <= bus.in_mem_data;
         memReq  <= (nextState == FETCH);
         memAddr <= (nextState == FETCH) ? nextBase + beatOffset : '0;
      end
   end

   assign bus.out_mem_req      = memReq;
   assign bus.out_mem_addr     = memAddr;
   assign bus.out_icache_valid = (state == RESP);
   assign bus.out_icache_data  = lineBuf;
   assign bus.out_busy         = (state != IDLE);
endmodule

// File: tb/tb_snow64_icache_line_fill_responder.sv
// Directed bench for the icache line-fill responder.
module tb_snow64_icache_line_fill_responder;
   logic clk;
   logic rst_n;
   int   nCmp;
   int   nBad;
   logic [255:0] prevLine;

   snow64_icache_line_fill_responder_if #(
      .WIDTH__LINE_DATA(256),
      .WIDTH__MEM_DATA(64),
      .WIDTH__CPU_ADDR(64)
   ) bus ();

   snow64_icache_line_fill_responder #(
      .WIDTH__LINE_DATA(256),
      .WIDTH__MEM_DATA(64),
      .WIDTH__CPU_ADDR(64)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] exp);
      nCmp++;
      if (obs !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Drives one complete fill, checking every beat address and the
   // response; optional stall before a beat and junk valids in RESP/IDLE.
   task automatic fill(input logic [63:0] a, input logic [255:0] line,
                       input int stallBeat, input int stallN,
                       input bit hold, input bit junk);
      logic [63:0] base;
      base = {a[63:5], 5'd0};
      bus.in_icache_req  = 1'b1;
      bus.in_icache_addr = a;
      @(posedge clk);
      #1;
      if (!hold) bus.in_icache_req = 1'b0;
      bus.in_icache_addr = 64'hDEAD_BEEF_0000_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) chk("bufHold", bus.out_icache_data, prevLine);
         if (i == stallBeat) begin
            for (int s = 0; s < stallN; s++) begin
               bus.in_mem_valid = 1'b0;
               chk("stallReq", 256'(bus.out_mem_req), 256'(1));
               chk("stallAddr", 256'(bus.out_mem_addr),
                   256'(base + 64'(i * 8)));
               @(negedge clk);
            end
         end
         chk("memReq", 256'(bus.out_mem_req), 256'(1));
         chk("memAddr", 256'(bus.out_mem_addr), 256'(base + 64'(i * 8)));
         chk("busyFetch", 256'(bus.out_busy), 256'(1));
         chk("noValid", 256'(bus.out_icache_valid), 256'(0));
         bus.in_mem_valid = 1'b1;
         bus.in_mem_data  = line[i*64 +: 64];
      end
      @(negedge clk);
      bus.in_mem_valid = junk;
      bus.in_mem_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      chk("respValid", 256'(bus.out_icache_valid), 256'(1));
      chk("respData", bus.out_icache_data, line);
      chk("respMemReq", 256'(bus.out_mem_req), 256'(0));
      chk("respMemAddr", 256'(bus.out_mem_addr), 256'(0));
      chk("respBusy", 256'(bus.out_busy), 256'(1));
      @(negedge clk);
      chk("idleValid", 256'(bus.out_icache_valid), 256'(0));
      chk("idleBusy", 256'(bus.out_busy), 256'(0));
      chk("idleMemReq", 256'(bus.out_mem_req), 256'(0));
      chk("idleData", bus.out_icache_data, line);
      bus.in_mem_valid = junk;
      prevLine = line;
   endtask

   initial begin
      nCmp = 0;
      nBad = 0;
      prevLine = '0;
      rst_n = 1'b0;
      bus.in_icache_req  = 1'b0;
      bus.in_icache_addr = '0;
      bus.in_mem_valid   = 1'b0;
      bus.in_mem_data    = '0;
      repeat (2) @(negedge clk);
      chk("rstValid", 256'(bus.out_icache_valid), 256'(0));
      chk("rstMemReq", 256'(bus.out_mem_req), 256'(0));
      chk("rstMemAddr", 256'(bus.out_mem_addr), 256'(0));
      chk("rstBusy", 256'(bus.out_busy), 256'(0));
      chk("rstData", bus.out_icache_data, 256'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Basic fill, then stalled fill on the same line.
      fill(64'h1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                      64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
           -1, 0, 1'b0, 1'b0);
      fill(64'h1234, {64'hA4A4_0000_0000_0004, 64'hA3A3_0000_0000_0003,
                      64'hA2A2_0000_0000_0002, 64'hA1A1_0000_0000_0001},
           2, 3, 1'b0, 1'b0);

      // Top line of the address space.
      fill(64'hFFFF_FFFF_FFFF_FFFF,
           {64'hF8F8_F8F8_F8F8_F8F8, 64'hF0F0_F0F0_F0F0_F0F0,
            64'hE8E8_E8E8_E8E8_E8E8, 64'hE0E0_E0E0_E0E0_E0E0},
           -1, 0, 1'b0, 1'b0);

      // Reset in the middle of a fill.
      bus.in_icache_req  = 1'b1;
      bus.in_icache_addr = 64'h80;
      @(posedge clk);
      #1 bus.in_icache_req = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         bus.in_mem_valid = 1'b1;
         bus.in_mem_data  = 64'h5555_0000_0000_0000 | 64'(i);
      end
      @(negedge clk);
      bus.in_mem_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("midRstMemReq", 256'(bus.out_mem_req), 256'(0));
      chk("midRstMemAddr", 256'(bus.out_mem_addr), 256'(0));
      chk("midRstValid", 256'(bus.out_icache_valid), 256'(0));
      chk("midRstBusy", 256'(bus.out_busy), 256'(0));
      chk("midRstData", bus.out_icache_data, 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      prevLine = '0;
      @(negedge clk);
      chk("postRstValid", 256'(bus.out_icache_valid), 256'(0));
      fill(64'h40, {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                    64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A},
           -1, 0, 1'b0, 1'b0);

      // Request held high: back-to-back fills, junk beats in RESP/IDLE.
      fill(64'h2008, {64'h6666_0000_0000_0003, 64'h6666_0000_0000_0002,
                      64'h6666_0000_0000_0001, 64'h6666_0000_0000_0000},
           -1, 0, 1'b1, 1'b1);
      fill(64'h3010, {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                      64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000},
           -1, 0, 1'b0, 1'b1);
      @(negedge clk);
      chk("junkIdleData", bus.out_icache_data,
          {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
           64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000});
      chk("junkIdleBusy", 256'(bus.out_busy), 256'(0));
      bus.in_mem_valid = 1'b0;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
